// File: rtl/time_set_ctrl.sv
// time_set_ctrl: user time-setting front end for the real-time clock.
// Debounces the mode/inc/dec buttons, steps through hours -> minutes -> seconds,
// edits a working copy of each field with wrap-around, and writes each finished
// value to the counter chain through the shared load/addrs/data_in port.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [5:0] q_seconds,
    input  logic [5:0] q_minutes,
    input  logic [5:0] q_hours,
    output logic       load,
    output logic [1:0] addrs,
    output logic [5:0] data_in,
    output logic       editing,
    output logic [1:0] field_sel
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [5:0] LIM_HR  = 6'd23;
    localparam logic [5:0] LIM_MS  = 6'd59;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] EDIT_HR  = 3'd1;
    localparam logic [2:0] WR_HR    = 3'd2;
    localparam logic [2:0] EDIT_MIN = 3'd3;
    localparam logic [2:0] WR_MIN   = 3'd4;
    localparam logic [2:0] EDIT_SEC = 3'd5;
    localparam logic [2:0] WR_SEC   = 3'd6;

    localparam logic [1:0] ADDR_SEC = 2'b00;
    localparam logic [1:0] ADDR_MIN = 2'b01;
    localparam logic [1:0] ADDR_HR  = 2'b10;

    logic [2:0] btn_raw;
    logic [2:0] press;
    logic       press_mode;
    logic       press_inc;
    logic       press_dec;

    logic [2:0] state;
    logic [5:0] edit_val;

    assign btn_raw    = {btn_dec, btn_inc, btn_mode};
    assign press_mode = press[0];
    assign press_inc  = press[1];
    assign press_dec  = press[2];

    // Captured counter values can be out of range; pin them to the field limit.
    function automatic logic [5:0] clamp_val(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // One edit step: inc and dec together cancel, otherwise wrap at the limit.
    function automatic logic [5:0] edit_step(input logic [5:0] v, input logic [5:0] lim,
                                             input logic inc, input logic dec);
        logic [5:0] r;
        r = v;
        if (inc && !dec)
            r = (v >= lim) ? 6'd0 : v + 6'd1;
        else if (dec && !inc)
            r = (v == 6'd0) ? lim : v - 6'd1;
        return r;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic             sync_0;
        logic             sync_1;
        logic             level;
        logic             press_r;
        logic [CNT_W-1:0] cnt;

        // Two-flop synchronizer, then a level that flips only after the
        // synchronized input has disagreed with it for DEBOUNCE_CYCLES cycles;
        // a rising flip emits a one-cycle press pulse.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_0  <= 1'b0;
                sync_1  <= 1'b0;
                level   <= 1'b0;
                press_r <= 1'b0;
                cnt     <= '0;
            end else begin
                sync_0  <= btn_raw[i];
                sync_1  <= sync_0;
                press_r <= 1'b0;
                if (sync_1 != level) begin
                    if (cnt == CNT_LAST) begin
                        level   <= sync_1;
                        press_r <= sync_1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign press[i] = press_r;
    end

    // Field-selection state machine and working copy of the field being edited.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            edit_val <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_mode) begin
                        state    <= EDIT_HR;
                        edit_val <= clamp_val(q_hours, LIM_HR);
                    end
                end
                EDIT_HR: begin
                    if (press_mode) state <= WR_HR;
                    else edit_val <= edit_step(edit_val, LIM_HR, press_inc, press_dec);
                end
                WR_HR: begin
                    state    <= EDIT_MIN;
                    edit_val <= clamp_val(q_minutes, LIM_MS);
                end
                EDIT_MIN: begin
                    if (press_mode) state <= WR_MIN;
                    else edit_val <= edit_step(edit_val, LIM_MS, press_inc, press_dec);
                end
                WR_MIN: begin
                    state    <= EDIT_SEC;
                    edit_val <= clamp_val(q_seconds, LIM_MS);
                end
                EDIT_SEC: begin
                    if (press_mode) state <= WR_SEC;
                    else edit_val <= edit_step(edit_val, LIM_MS, press_inc, press_dec);
                end
                WR_SEC:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    always_comb begin
        load      = 1'b0;
        addrs     = ADDR_SEC;
        data_in   = 6'd0;
        editing   = (state != IDLE);
        field_sel = 2'b11;
        case (state)
            EDIT_HR:  field_sel = ADDR_HR;
            EDIT_MIN: field_sel = ADDR_MIN;
            EDIT_SEC: field_sel = ADDR_SEC;
            WR_HR: begin
                field_sel = ADDR_HR;
                load      = 1'b1;
                addrs     = ADDR_HR;
                data_in   = edit_val;
            end
            WR_MIN: begin
                field_sel = ADDR_MIN;
                load      = 1'b1;
                addrs     = ADDR_MIN;
                data_in   = edit_val;
            end
            WR_SEC: begin
                field_sel = ADDR_SEC;
                load      = 1'b1;
                addrs     = ADDR_SEC;
                data_in   = edit_val;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a field-level model predicts every
// counter write; a monitor compares each load pulse against the queue.
module tb_time_set_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc, btn_dec;
    logic [5:0] q_seconds, q_minutes, q_hours;
    logic       load;
    logic [1:0] addrs;
    logic [5:0] data_in;
    logic       editing;
    logic [1:0] field_sel;

    typedef struct packed {
        logic [1:0] a;
        logic [5:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    // model: 0 = not editing, 1 = hours, 2 = minutes, 3 = seconds
    int  m_field = 0;
    int  m_val = 0;

    always #5 clk = ~clk;

    time_set_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .q_seconds(q_seconds), .q_minutes(q_minutes), .q_hours(q_hours),
        .load(load), .addrs(addrs), .data_in(data_in),
        .editing(editing), .field_sel(field_sel)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int q, input int lim);
        return (q > lim) ? lim : q;
    endfunction

    // Field-level reference behaviour for one debounced event set.
    task automatic model_event(input bit mo, input bit in, input bit de);
        int lim;
        if (mo) begin
            case (m_field)
                0: begin m_field = 1; m_val = clampv(int'(q_hours), 23); end
                1: begin exp_q.push_back('{2'b10, 6'(m_val)}); m_field = 2; m_val = clampv(int'(q_minutes), 59); end
                2: begin exp_q.push_back('{2'b01, 6'(m_val)}); m_field = 3; m_val = clampv(int'(q_seconds), 59); end
                default: begin exp_q.push_back('{2'b00, 6'(m_val)}); m_field = 0; end
            endcase
        end else if (m_field != 0 && in != de) begin
            lim = (m_field == 1) ? 23 : 59;
            if (in) m_val = (m_val + 1) % (lim + 1);
            else    m_val = (m_val + lim) % (lim + 1);
        end
    endtask

    function automatic int exp_sel();
        case (m_field)
            1: return 2;
            2: return 1;
            3: return 0;
            default: return 3;
        endcase
    endfunction

    // Clean press: hold, release, settle, then check the visible field state.
    task automatic press(input bit mo, input bit in, input bit de);
        model_event(mo, in, de);
        btn_mode = mo; btn_inc = in; btn_dec = de;
        repeat (D + 4) @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (D + 6) @(negedge clk);
        chk("editing", int'(editing), (m_field != 0) ? 1 : 0);
        chk("field_sel", int'(field_sel), exp_sel());
    endtask

    // Monitor: every load pulse must match the oldest predicted write.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_load: addrs=%0d data_in=%0d, required no write", addrs, data_in);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addrs", int'(addrs), int'(e.a));
                chk("wr_data", int'(data_in), int'(e.d));
            end
        end else if (load === 1'b0) begin
            if (addrs !== 2'b00 || data_in !== 6'd0) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_port: addrs=%0d data_in=%0d, required 0/0", addrs, data_in);
            end
        end
    end

    initial begin
        bit found;
        int op;
        reset = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        q_seconds = 6'd0; q_minutes = 6'd0; q_hours = 6'd0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_load", int'(load), 0);
        chk("rst_addrs", int'(addrs), 0);
        chk("rst_data", int'(data_in), 0);
        chk("rst_editing", int'(editing), 0);
        chk("rst_field_sel", int'(field_sel), 3);
        reset = 1'b0;

        // inc held in IDLE does nothing
        btn_inc = 1'b1;
        repeat (20) @(negedge clk);
        btn_inc = 1'b0;
        repeat (D + 6) @(negedge clk);
        chk("idle_inc_editing", int'(editing), 0);

        // debounce: short glitches produce no event
        q_hours = 6'd22; q_minutes = 6'd0; q_seconds = 6'd37;
        btn_mode = 1'b1; repeat (3) @(negedge clk);
        btn_mode = 1'b0; repeat (2) @(negedge clk);
        btn_mode = 1'b1; repeat (3) @(negedge clk);
        btn_mode = 1'b0; repeat (D + 6) @(negedge clk);
        chk("glitch_editing", int'(editing), 0);
        chk("glitch_field_sel", int'(field_sel), 3);

        // a 7-cycle hold enters hours
        model_event(1'b1, 1'b0, 1'b0);
        btn_mode = 1'b1; repeat (7) @(negedge clk);
        btn_mode = 1'b0; repeat (D + 6) @(negedge clk);
        chk("enter_editing", int'(editing), 1);
        chk("enter_field_sel", int'(field_sel), 2);

        // hours 22 -> 23 -> 0 -> 1, write
        repeat (3) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        // minutes 0 -> 59, write; seconds captured as 37
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        // simultaneous inc+dec, then mode+inc
        press(1'b0, 1'b1, 1'b1);
        press(1'b1, 1'b1, 1'b0);

        // randomized operations, including out-of-range captures
        for (int i = 0; i < 40; i++) begin
            q_hours   = 6'($urandom_range(0, 63));
            q_minutes = 6'($urandom_range(0, 63));
            q_seconds = 6'($urandom_range(0, 63));
            op = $urandom_range(0, 5);
            case (op)
                0: press(1'b1, 1'b0, 1'b0);
                1: press(1'b0, 1'b1, 1'b0);
                2: press(1'b0, 1'b0, 1'b1);
                3: press(1'b0, 1'b1, 1'b1);
                4: press(1'b1, 1'b1, 1'b0);
                default: press(1'b1, 1'b0, 1'b1);
            endcase
        end
        while (m_field != 0) press(1'b1, 1'b0, 1'b0);

        // reset while in EDIT_SEC
        repeat (3) press(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_field = 0;
        chk("rst_sec_editing", int'(editing), 0);
        chk("rst_sec_field_sel", int'(field_sel), 3);
        chk("rst_sec_load", int'(load), 0);
        repeat (2 * D + 10) @(negedge clk);

        // reset landing right after the WR_MIN cycle
        repeat (2) press(1'b1, 1'b0, 1'b0);
        model_event(1'b1, 1'b0, 1'b0);
        btn_mode = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (load === 1'b1 && addrs === 2'b01) found = 1'b1;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL wr_min_timeout: no minutes write within 40 cycles, required one");
        end
        reset = 1'b1;
        btn_mode = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_field = 0;
        chk("rst_wr_load", int'(load), 0);
        chk("rst_wr_editing", int'(editing), 0);
        chk("rst_wr_field_sel", int'(field_sel), 3);
        repeat (2 * D + 10) @(negedge clk);
        chk("post_rst_editing", int'(editing), 0);

        chk("pending_writes", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
